// File: rtl/alu_sequencer.sv
// Multi-cycle register-file sequencer that feeds an external 16-bit ALU.
// Each instruction walks LOAD_A -> LOAD_B -> EXEC -> WRITE; preloads happen only in IDLE.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [2:0]  rd,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  input  logic [1:0]  shift,
  input  logic        load_valid,
  input  logic [2:0]  load_num,
  input  logic [15:0] load_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  output logic [15:0] result,
  output logic        status_z,
  output logic        done,
  input  logic [2:0]  dbg_num,
  output logic [15:0] dbg_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] r_q [8];
  logic [15:0] r_d [8];
  logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic        z_q, z_d, done_q, done_d;
  logic [1:0]  op_q, op_d, shift_q, shift_d;
  logic [2:0]  rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;

  function automatic logic [15:0] shift_b(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'b00:   shift_b = v;
      2'b01:   shift_b = {v[14:0], 1'b0};
      2'b10:   shift_b = {1'b0, v[15:1]};
      2'b11:   shift_b = {v[15], v[15:1]};
      default: shift_b = v;
    endcase
  endfunction

  // Next-state and datapath updates; done_d is set on EXEC so done_q is high exactly during WRITE.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    done_d  = 1'b0;
    op_d    = op_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          r_d[load_num] = load_data;
        end else if (in_valid) begin
          op_d    = op;
          shift_d = shift;
          rd_d    = rd;
          rn_d    = rn;
          rm_d    = rm;
          state_d = LOAD_A;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_A: begin
        a_d     = r_q[rn_q];
        state_d = LOAD_B;
      end
      LOAD_B: begin
        b_d     = shift_b(r_q[rm_q], shift_q);
        state_d = EXEC;
      end
      EXEC: begin
        c_d     = alu_out;
        z_d     = alu_z;
        done_d  = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        r_d[rd_q] = c_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < 8; i++) r_q[i] <= 16'h0000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      c_q     <= 16'h0000;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= 2'b00;
      shift_q <= 2'b00;
      rd_q    <= 3'd0;
      rn_q    <= 3'd0;
      rm_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      done_q  <= done_d;
      op_q    <= op_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
    end
  end

  // reset is folded in so in_ready reads 0 the moment reset asserts.
  assign in_ready = (state_q == IDLE) && !load_valid && !reset;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign result   = c_q;
  assign status_z = z_q;
  assign done     = done_q;
  assign dbg_data = r_q[dbg_num];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against an arithmetic reference model.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  op, shift, alu_op;
  logic [2:0]  rd, rn, rm, load_num, dbg_num;
  logic        load_valid;
  logic [15:0] load_data, alu_a, alu_b, alu_out, result, dbg_data;
  logic        alu_z, status_z, done;

  int checks = 0;
  int errors = 0;
  int unsigned mdl_r [8];
  int unsigned mdl_a, mdl_b, mdl_c, mdl_z;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .shift(shift),
    .load_valid(load_valid), .load_num(load_num), .load_data(load_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .result(result), .status_z(status_z), .done(done),
    .dbg_num(dbg_num), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU that the sequencer drives.
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = ~alu_b;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_shift(input int unsigned v, input int s);
    case (s)
      1:       return (v * 2) % 65536;
      2:       return v / 2;
      3:       return v / 2 + ((v >= 32768) ? 32768 : 0);
      default: return v;
    endcase
  endfunction

  function automatic int unsigned ref_alu(input int o, input int unsigned a, input int unsigned b);
    case (o)
      0:       return (a + b) % 65536;
      1:       return (a + 65536 - b) % 65536;
      2:       return a & b;
      default: return 65535 - b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl_r[i] = 0;
    mdl_a = 0; mdl_b = 0; mdl_c = 0; mdl_z = 0;
  endtask

  task automatic do_load(input int n, input int unsigned d);
    @(negedge clk);
    load_valid = 1'b1;
    load_num   = n[2:0];
    load_data  = d[15:0];
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    mdl_r[n]   = d;
  endtask

  task automatic run_instr(input int o, input int d, input int n, input int m, input int s);
    int cyc;
    bit seen;
    mdl_a = mdl_r[n];
    mdl_b = ref_shift(mdl_r[m], s);
    mdl_c = ref_alu(o, mdl_a, mdl_b);
    mdl_z = (mdl_c == 0) ? 1 : 0;
    mdl_r[d] = mdl_c;
    @(negedge clk);
    in_valid = 1'b1;
    op = o[1:0]; rd = d[2:0]; rn = n[2:0]; rm = m[2:0]; shift = s[1:0];
    check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 2'($urandom); rd = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom); shift = 2'($urandom);
    cyc = 0;
    seen = 1'b0;
    while (cyc < 8 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    check_eq("done_latency", cyc, 32'd3);
    check_eq("result", {16'd0, result}, mdl_c);
    check_eq("status_z", {31'd0, status_z}, mdl_z);
    check_eq("alu_a", {16'd0, alu_a}, mdl_a);
    check_eq("alu_b", {16'd0, alu_b}, mdl_b);
    @(posedge clk);
    #1;
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    dbg_num = d[2:0];
    #1;
    check_eq("writeback", {16'd0, dbg_data}, mdl_r[d]);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_num = i[2:0];
      #1;
      check_eq(tag, {16'd0, dbg_data}, mdl_r[i]);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; load_valid = 1'b0;
    op = 2'd0; rd = 3'd0; rn = 3'd0; rm = 3'd0; shift = 2'd0;
    load_num = 3'd0; load_data = 16'd0; dbg_num = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("ready_in_reset", {31'd0, in_ready}, 32'd0);
    check_eq("reset_result", {16'd0, result}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("ready_after_reset", {31'd0, in_ready}, 32'd1);

    do_load(0, 5);
    do_load(1, 2);
    run_instr(1, 2, 0, 1, 0);
    check_eq("sub_const", {16'd0, result}, 32'd3);
    run_instr(0, 3, 0, 1, 1);
    check_eq("add_lsl_const", {16'd0, result}, 32'd9);
    run_instr(0, 3, 3, 3, 0);
    check_eq("add_self_const", {16'd0, result}, 32'd18);
    do_load(4, 16'hFFFF);
    do_load(5, 1);
    run_instr(0, 6, 4, 5, 0);
    check_eq("wrap_z", {31'd0, status_z}, 32'd1);
    do_load(7, 16'h8000);
    run_instr(3, 7, 0, 7, 3);
    check_eq("asr_b", {16'd0, alu_b}, 32'h0000C000);
    check_eq("not_r7", {16'd0, dbg_data}, 32'h00003FFF);
    run_instr(2, 1, 7, 6, 0);
    check_eq("and_z", {31'd0, status_z}, 32'd1);

    // load and instruction offered together: load wins, instruction follows.
    @(negedge clk);
    load_valid = 1'b1; load_num = 3'd2; load_data = 16'h1234;
    in_valid = 1'b1; op = 2'd0; rd = 3'd5; rn = 3'd2; rm = 3'd2; shift = 2'd0;
    #1;
    check_eq("ready_low_on_load", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    in_valid = 1'b0;
    mdl_r[2] = 16'h1234;
    run_instr(0, 5, 2, 2, 0);
    check_regs("regs_mid");

    // Reset pulsed during EXEC aborts the instruction.
    @(negedge clk);
    in_valid = 1'b1; op = 2'd0; rd = 3'd4; rn = 3'd2; rm = 3'd3; shift = 2'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("abort_ready", {31'd0, in_ready}, 32'd0);
    check_eq("abort_alu_a", {16'd0, alu_a}, 32'd0);
    check_eq("abort_alu_b", {16'd0, alu_b}, 32'd0);
    check_eq("abort_alu_op", {30'd0, alu_op}, 32'd0);
    check_eq("abort_status", {31'd0, status_z}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_result", {16'd0, result}, 32'd0);
    check_regs("abort_regs");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("ready_after_abort", {31'd0, in_ready}, 32'd1);
    run_instr(3, 0, 1, 1, 0);

    for (int it = 0; it < 40; it++) begin
      int nl;
      nl = $urandom_range(0, 2);
      for (int k = 0; k < nl; k++) do_load($urandom_range(0, 7), $urandom_range(0, 65535));
      check_eq("result_hold", {16'd0, result}, mdl_c);
      check_eq("status_hold", {31'd0, status_z}, mdl_z);
      run_instr($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 3));
    end
    check_regs("regs_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  instruction accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-006 op  input  2  ALU operation: 00 A+B, 01 A-B, 10 A&B, 11 ~B.
REQ-007 rd, rn, rm  input  3 each  destination, A-source and B-source register numbers.
REQ-008 shift  input  2  B-operand shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
REQ-009 load_valid  input  1  register preload request.
REQ-010 load_num  input  3  preload register number.
REQ-011 load_data  input  16  preload value.
REQ-012 alu_a, alu_b  output  16 each  operands to the external ALU.
REQ-013 alu_op  output  2  operation code to the external ALU.
REQ-014 alu_out  input  16  ALU result.
REQ-015 alu_z  input  1  ALU zero flag.
REQ-016 result  output  16  C register (last ALU result).
REQ-017 status_z  output  1  registered Z flag.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 dbg_num  input  3  debug read select.
REQ-020 dbg_data  output  16  combinational read of R[dbg_num].

Function
REQ-021 The block SHALL contain eight 16-bit registers R0-R7 and the 16-bit registers A, B and C.
REQ-022 The state machine SHALL use the states IDLE, LOAD_A, LOAD_B, EXEC and WRITE; each non-IDLE state SHALL last exactly one cycle.
REQ-023 in_ready SHALL equal (state==IDLE) and not load_valid.
REQ-024 IDLE: when load_valid is 1, the block SHALL write R[load_num]=load_data at the edge and SHALL stay in IDLE.
REQ-025 load_valid outside IDLE SHALL be ignored.
REQ-026 IDLE: on acceptance, the block SHALL latch op, rd, rn, rm and shift, and go to LOAD_A.
REQ-027 LOAD_A: A SHALL be set to R[rn], then the state SHALL go to LOAD_B.
REQ-028 LOAD_A: A SHALL be loaded even when op=11.
REQ-029 LOAD_B: B SHALL be set to shift(R[rm]), then the state SHALL go to EXEC.
REQ-030 LSL1 and LSR1 SHALL fill with 0; ASR1 SHALL replicate bit 15.
REQ-031 alu_a and alu_b SHALL always drive A and B; alu_op SHALL always drive the latched op.
REQ-032 EXEC: C SHALL be set to alu_out and status_z to alu_z, then the state SHALL go to WRITE.
REQ-033 WRITE: R[rd] SHALL be set to C, done SHALL be 1 for this cycle only, and the next state SHALL be IDLE.
REQ-034 Latency: done SHALL assert in the 4th cycle after the acceptance edge; throughput SHALL be one instruction per 5 cycles.
REQ-035 Arithmetic SHALL be modulo 2^16; carry and borrow SHALL be discarded.
REQ-036 An instruction accepted right after done SHALL read the updated R[rd] (rd==rn or rd==rm is legal).
REQ-037 result and status_z SHALL hold their values until the next EXEC.

Reset
REQ-038 Asserting reset SHALL immediately force: state=IDLE, R0-R7=0, A=B=C=0, status_z=0, done=0, latched op=00.
REQ-039 Reset during any non-IDLE state SHALL abort the instruction with no register write-back.
REQ-040 in_ready SHALL be 0 while reset is high and SHALL be 1 in the first cycle after release (when load_valid=0).

Verification
REQ-041 Preload R0=5 and R1=2, then SUB rd=2 rn=0 rm=1 shift=00 -> done 4 cycles after accept, R2=3, result=3, status_z=0.
REQ-042 ADD rd=3 rn=0 rm=1 shift=LSL1 (5+4) -> R3=9; then ADD rd=3 rn=3 rm=3 -> R3=18.
REQ-043 Preload R4=0xFFFF and R5=1, then ADD rd=6 rn=4 rm=5 -> R6=0x0000, status_z=1.
REQ-044 Preload R7=0x8000, then NOT rd=7 rm=7 shift=ASR1 -> B=0xC000, R7=0x3FFF, status_z=0; then AND with R6 -> status_z=1.
REQ-045 load_valid and in_valid both high in IDLE -> load is performed, in_ready=0, and the instruction is accepted the next cycle.
REQ-046 Reset pulsed during EXEC -> no done, R[rd] unchanged (0), all outputs at reset values, new instruction accepted after release.
